// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - shared move format, FIFO word sizing and collector state encoding
package chess_pkg;
    localparam int MOVE_W = 19;
    localparam int SLOTS  = 8;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int WORD_W = MOVE_W * SLOTS;

    // Move flag bit positions
    localparam int FLG_INVALID = 18;
    localparam int FLG_PROMOTE = 17;
    localparam int FLG_PAWN    = 16;
    localparam int FLG_PAWN2   = 15;
    localparam int FLG_EP      = 14;
    localparam int FLG_CASTLE  = 13;
    localparam int FLG_CAPTURE = 12;

    // Square fields
    localparam int FROM_HI = 11;
    localparam int FROM_LO = 6;
    localparam int TO_HI   = 5;
    localparam int TO_LO   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_RDWAIT,
        ST_EMIT,
        ST_DONE
    } state_t;
endpackage

// File: rtl/move_unpacker.sv
// rtl/move_unpacker.sv - holds one FIFO word and walks its slots from 7 down to 0
module move_unpacker
    import chess_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    input  logic              active,
    input  logic              move_ready,
    output logic [MOVE_W-1:0] move_data,
    output logic              move_valid,
    output logic              accept,
    output logic              skip,
    output logic              last
);
    logic [WORD_W-1:0] word;
    logic [SLOT_W-1:0] slot;
    logic [MOVE_W-1:0] cur;

    // Present the current slot; invalid slots are consumed without a handshake
    always_comb begin
        cur        = word[MOVE_W*slot +: MOVE_W];
        move_valid = active && !cur[FLG_INVALID];
        move_data  = move_valid ? cur : '0;
        accept     = move_valid && move_ready;
        skip       = active && cur[FLG_INVALID];
        last       = (accept || skip) && (slot == '0);
    end

    // Word capture and slot countdown; slot wraps 0 -> 7 ready for the next word
    always_ff @(posedge clk) begin
        if (reset) begin
            word <= '0;
            slot <= SLOT_W'(SLOTS - 1);
        end else if (load) begin
            word <= load_word;
            slot <= SLOT_W'(SLOTS - 1);
        end else if (accept || skip) begin
            slot <= slot - 1'b1;
        end
    end
endmodule

// File: rtl/move_collector.sv
// rtl/move_collector.sv - drains column move FIFOs in order and streams legal moves; MOVE_COLLECTOR_STATS_EN adds capture/skip counters
module move_collector
    import chess_pkg::*;
#(
    parameter int NCOL  = 8,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NCOL-1:0]        col_done,
    input  logic [NCOL-1:0]        col_empty,
    input  logic [NCOL*WORD_W-1:0] col_data,
    output logic [NCOL-1:0]        col_rden,
    output logic [MOVE_W-1:0]      move_data,
    output logic                   move_valid,
    input  logic                   move_ready,
    output logic [CNT_W-1:0]       move_count,
    output logic                   busy,
    output logic                   all_done
`ifdef MOVE_COLLECTOR_STATS_EN
    ,
    output logic [CNT_W-1:0]       capture_count,
    output logic [CNT_W-1:0]       skip_count
`endif
);
    localparam int PTR_W = (NCOL > 1) ? $clog2(NCOL) : 1;

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [WORD_W-1:0] col_word [NCOL];
    logic              start_ok;
    logic              accept;
    logic              skip;
    logic              last;

    for (genvar c = 0; c < NCOL; c++) begin : g_slice
        assign col_word[c] = col_data[WORD_W*c +: WORD_W];
    end

    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

    // Read enable goes out in the POLL cycle so the word lands during RDWAIT
    always_comb begin
        col_rden = '0;
        if ((state == ST_POLL) && !col_empty[ptr])
            col_rden[ptr] = 1'b1;
    end

    // Column arbitration FSM with move counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            busy       <= 1'b0;
            all_done   <= 1'b0;
            move_count <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        ptr        <= '0;
                        move_count <= '0;
                        all_done   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_POLL;
                    end
                end
                ST_POLL: begin
                    // Pending data wins over done so a column is fully drained first
                    if (!col_empty[ptr]) begin
                        state <= ST_RDWAIT;
                    end else if (col_done[ptr]) begin
                        if (ptr == PTR_W'(NCOL - 1)) begin
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            all_done <= 1'b1;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                ST_RDWAIT: state <= ST_EMIT;
                ST_EMIT: begin
                    if (accept && (move_count != '1))
                        move_count <= move_count + 1'b1;
                    if (last)
                        state <= ST_POLL;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    move_unpacker u_unpacker (
        .clk        (clk),
        .reset      (reset),
        .load       (state == ST_RDWAIT),
        .load_word  (col_word[ptr]),
        .active     (state == ST_EMIT),
        .move_ready (move_ready),
        .move_data  (move_data),
        .move_valid (move_valid),
        .accept     (accept),
        .skip       (skip),
        .last       (last)
    );

`ifdef MOVE_COLLECTOR_STATS_EN
    // Saturating statistics over the current collection
    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            capture_count <= '0;
            skip_count    <= '0;
        end else begin
            if (accept && move_data[FLG_CAPTURE] && (capture_count != '1))
                capture_count <= capture_count + 1'b1;
            if (skip && (skip_count != '1))
                skip_count <= skip_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_move_collector.sv
// tb/tb_move_collector.sv - randomized self-checking bench for move_collector with FIFO and move-list model
`timescale 1ns/1ps
module tb_move_collector;
    localparam int NCOL  = 8;
    localparam int MW    = 19;
    localparam int WW    = 152;
    localparam int DEPTH = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [NCOL-1:0]  col_done;
    logic [NCOL-1:0]  col_empty;
    logic [NCOL*WW-1:0] col_data;
    logic [NCOL-1:0]  col_rden;
    logic [MW-1:0]    move_data;
    logic             move_valid;
    logic             move_ready;
    logic [7:0]       move_count;
    logic             busy;
    logic             all_done;
`ifdef MOVE_COLLECTOR_STATS_EN
    logic [7:0]       capture_count;
    logic [7:0]       skip_count;
`endif

    int vectors = 0;
    int errors  = 0;

    logic [WW-1:0] mem [NCOL][DEPTH];
    int            wr_ptr [NCOL] = '{default: 0};
    int            rd_ptr [NCOL] = '{default: 0};
    logic [WW-1:0] rdata  [NCOL] = '{default: '0};
    int            rden_cnt [NCOL] = '{default: 0};
    logic [MW-1:0] got[$];
    logic [MW-1:0] exp_q[$];

    always #5 clk = ~clk;

    move_collector dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .col_done   (col_done),
        .col_empty  (col_empty),
        .col_data   (col_data),
        .col_rden   (col_rden),
        .move_data  (move_data),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move_count (move_count),
        .busy       (busy),
        .all_done   (all_done)
`ifdef MOVE_COLLECTOR_STATS_EN
        ,
        .capture_count (capture_count),
        .skip_count    (skip_count)
`endif
    );

    // Column FIFO models: one-cycle read latency
    always_comb begin
        col_data = '0;
        for (int c = 0; c < NCOL; c++) begin
            col_empty[c] = (rd_ptr[c] == wr_ptr[c]);
            col_data[WW*c +: WW] = rdata[c];
        end
    end

    always @(posedge clk) begin
        for (int c = 0; c < NCOL; c++) begin
            if (col_rden[c]) begin
                rdata[c]  <= mem[c][rd_ptr[c] % DEPTH];
                rd_ptr[c] <= rd_ptr[c] + 1;
            end
        end
    end

    // Handshake / read-enable monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (move_valid && move_ready) got.push_back(move_data);
            for (int c = 0; c < NCOL; c++) if (col_rden[c]) rden_cnt[c]++;
            if (move_valid) begin
                vectors++;
                if (!busy) begin
                    errors++;
                    $display("FAIL valid_while_idle: move_valid=1 busy=%0b, required busy=1", busy);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; move_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic clear_all();
        for (int c = 0; c < NCOL; c++) begin
            wr_ptr[c]   = rd_ptr[c];
            rden_cnt[c] = 0;
        end
        col_done = '0;
        got.delete();
        exp_q.delete();
    endtask

    task automatic push_word(input int c, input logic [WW-1:0] w);
        mem[c][wr_ptr[c] % DEPTH] = w;
        wr_ptr[c]++;
    endtask

    // Reference: columns in order, words in FIFO order, slots 7..0, keep non-invalid
    task automatic build_expected();
        logic [WW-1:0] w;
        logic [MW-1:0] m;
        exp_q.delete();
        for (int c = 0; c < NCOL; c++)
            for (int i = rd_ptr[c]; i < wr_ptr[c]; i++) begin
                w = mem[c][i % DEPTH];
                for (int s = 7; s >= 0; s--) begin
                    m = w[MW*s +: MW];
                    if (!m[18]) exp_q.push_back(m);
                end
            end
    endtask

    function automatic logic [MW-1:0] rand_move(input bit valid);
        logic [MW-1:0] m;
        m[17:0] = 18'($urandom);
        m[18]   = !valid;
        return m;
    endfunction

    function automatic logic [WW-1:0] rand_word(input int pct_valid);
        logic [WW-1:0] w;
        for (int s = 0; s < 8; s++)
            w[MW*s +: MW] = rand_move($urandom_range(0, 99) < pct_valid);
        return w;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, input string name);
        int n = 0;
        while (!all_done && n < budget) begin
            move_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        vectors++;
        if (!all_done) begin
            errors++;
            $display("FAIL %s_timeout: all_done=%0b after %0d cycles, required 1", name, all_done, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 6;
        if (col_rden !== 8'h00)    begin errors++; $display("FAIL reset_rden: got %h, required 00", col_rden); end
        if (move_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b, required 0", move_valid); end
        if (move_data !== 19'h0)   begin errors++; $display("FAIL reset_data: got %h, required 0", move_data); end
        if (move_count !== 8'h00)  begin errors++; $display("FAIL reset_count: got %0d, required 0", move_count); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (all_done !== 1'b0)     begin errors++; $display("FAIL reset_all_done: got %b, required 0", all_done); end
    endtask

    task automatic test_basic();
        int others = 0;
        do_reset(); clear_all();
        push_word(0, {19'h00F1C, 19'h00F24, {6{19'h40000}}});
        col_done = '1;
        pulse_start();
        wait_done(200, 1'b0, "basic");
        for (int c = 1; c < NCOL; c++) others += rden_cnt[c];
        vectors += 7;
        if (got.size() != 2) begin errors++; $display("FAIL basic_nmoves: got %0d, required 2", got.size()); end
        else begin
            if (got[0] !== 19'h00F1C) begin errors++; $display("FAIL basic_move0: got %h, required 00f1c", got[0]); end
            if (got[1] !== 19'h00F24) begin errors++; $display("FAIL basic_move1: got %h, required 00f24", got[1]); end
        end
        if (move_count !== 8'd2)  begin errors++; $display("FAIL basic_count: got %0d, required 2", move_count); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL basic_busy: got %b, required 0", busy); end
        if (rden_cnt[0] != 1)     begin errors++; $display("FAIL basic_rden0: got %0d pulses, required 1", rden_cnt[0]); end
        if (others != 0)          begin errors++; $display("FAIL basic_rden_other: got %0d pulses, required 0", others); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset(); clear_all();
        push_word(0, {19'h00F1C, 19'h00F24, {6{19'h40000}}});
        col_done = '1;
        move_ready = 1'b0;
        pulse_start();
        while (!move_valid && n < 20) begin tick(); n++; end
        for (int i = 0; i < 5; i++) begin
            vectors += 3;
            if (move_valid !== 1'b1)   begin errors++; $display("FAIL bp_valid%0d: got %b, required 1", i, move_valid); end
            if (move_data !== 19'h00F1C) begin errors++; $display("FAIL bp_data%0d: got %h, required 00f1c", i, move_data); end
            if (move_count !== 8'd0)   begin errors++; $display("FAIL bp_count%0d: got %0d, required 0", i, move_count); end
            tick();
        end
        move_ready = 1'b1;
        tick();
        vectors += 2;
        if (move_count !== 8'd1)     begin errors++; $display("FAIL bp_count_hs: got %0d, required 1", move_count); end
        if (move_data !== 19'h00F24) begin errors++; $display("FAIL bp_second: got %h, required 00f24", move_data); end
        wait_done(200, 1'b0, "bp");
        vectors++;
        if (move_count !== 8'd2) begin errors++; $display("FAIL bp_final_count: got %0d, required 2", move_count); end
    endtask

    task automatic test_stall();
        int sum = 0;
        do_reset(); clear_all();
        col_done = 8'b0000_0111;
        pulse_start();
        repeat (20) tick();
        for (int c = 0; c < NCOL; c++) sum += rden_cnt[c];
        vectors += 3;
        if (busy !== 1'b1)     begin errors++; $display("FAIL stall_busy: got %b, required 1", busy); end
        if (all_done !== 1'b0) begin errors++; $display("FAIL stall_done: got %b, required 0", all_done); end
        if (sum != 0)          begin errors++; $display("FAIL stall_rden: got %0d pulses, required 0", sum); end
        push_word(3, rand_word(70));
        push_word(5, rand_word(70));
        col_done = '1;
        build_expected();
        wait_done(400, 1'b1, "stall");
        vectors += 4;
        if (got.size() != exp_q.size()) begin errors++; $display("FAIL stall_nmoves: got %0d, required %0d", got.size(), exp_q.size()); end
        else for (int i = 0; i < got.size(); i++) begin
            vectors++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL stall_move%0d: got %h, required %h", i, got[i], exp_q[i]); end
        end
        if (move_count !== 8'(exp_q.size())) begin errors++; $display("FAIL stall_count: got %0d, required %0d", move_count, exp_q.size()); end
        if (rden_cnt[3] != 1) begin errors++; $display("FAIL stall_rden3: got %0d, required 1", rden_cnt[3]); end
        if (rden_cnt[5] != 1) begin errors++; $display("FAIL stall_rden5: got %0d, required 1", rden_cnt[5]); end
    endtask

    task automatic test_reset_mid();
        logic [WW-1:0] w;
        int n = 0;
        do_reset(); clear_all();
        w = rand_word(100);
        push_word(0, w);
        col_done = '1;
        pulse_start();
        while (!move_valid && n < 20) begin tick(); n++; end
        move_ready = 1'b1;
        repeat (3) tick();
        vectors++;
        if (move_data !== w[MW*4 +: MW]) begin errors++; $display("FAIL mid_slot4: got %h, required %h", move_data, w[MW*4 +: MW]); end
        reset = 1'b1; move_ready = 1'b0;
        tick();
        vectors += 5;
        if (move_valid !== 1'b0)  begin errors++; $display("FAIL mid_valid: got %b, required 0", move_valid); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL mid_busy: got %b, required 0", busy); end
        if (move_count !== 8'd0)  begin errors++; $display("FAIL mid_count: got %0d, required 0", move_count); end
        if (col_rden !== 8'h00)   begin errors++; $display("FAIL mid_rden: got %h, required 00", col_rden); end
        if (move_data !== 19'h0)  begin errors++; $display("FAIL mid_data: got %h, required 0", move_data); end
        reset = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset(); clear_all();
        for (int c = 0; c < NCOL; c++) repeat (4) push_word(c, rand_word(100));
        col_done = '1;
        pulse_start();
        wait_done(3000, 1'b0, "sat");
        vectors += 2;
        if (move_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d, required 255", move_count); end
        if (got.size() != 256)     begin errors++; $display("FAIL sat_nmoves: got %0d, required 256", got.size()); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            do_reset(); clear_all();
            for (int c = 0; c < NCOL; c++) repeat ($urandom_range(0, 3)) push_word(c, rand_word($urandom_range(0, 100)));
            col_done = '1;
            build_expected();
            pulse_start();
            wait_done(4000, 1'b1, "rand");
            vectors += 2;
            if (got.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_nmoves: got %0d, required %0d", it, got.size(), exp_q.size()); end
            else for (int i = 0; i < got.size(); i++) begin
                vectors++;
                if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_move%0d: got %h, required %h", it, i, got[i], exp_q[i]); end
            end
            if (move_count !== 8'(exp_q.size())) begin errors++; $display("FAIL rand%0d_count: got %0d, required %0d", it, move_count, exp_q.size()); end
        end
    endtask

`ifdef MOVE_COLLECTOR_STATS_EN
    task automatic test_stats();
        logic [WW-1:0] w;
        do_reset(); clear_all();
        for (int s = 0; s < 8; s++) begin
            w[MW*s +: MW] = rand_move(s == 7 || s == 4 || s == 1);
            w[MW*s + 12]  = 1'b1;
        end
        push_word(0, w);
        col_done = '1;
        pulse_start();
        wait_done(200, 1'b1, "stats");
        vectors += 3;
        if (capture_count !== 8'd3) begin errors++; $display("FAIL stats_capture: got %0d, required 3", capture_count); end
        if (skip_count !== 8'd5)    begin errors++; $display("FAIL stats_skip: got %0d, required 5", skip_count); end
        if (move_count !== 8'd3)    begin errors++; $display("FAIL stats_count: got %0d, required 3", move_count); end
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; move_ready = 1'b0; col_done = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_saturate();
        test_random();
`ifdef MOVE_COLLECTOR_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/move_collector.md
Name: move_collector

Overview:
- Downstream of the eight column move generators (one per file, xpos 0..7).
- Drains each column's 152-bit move FIFO word: 8 slots x 19-bit moves.
- Unpacks each word and discards invalid/terminator slots.
- Streams legal moves one at a time over a valid/ready interface to the search/evaluation stage. Signals completion when all columns are exhausted.

Parameters:
- NCOL, 8, number of column units served
- MOVE_W, 19, move width: [18 invalid][17 promote][16 pawn move][15 pawn 2 sq][14 en passant][13 castle][12 capture][11:6 from][5:0 to]
- SLOTS, 8, moves per column FIFO word
- CNT_W, 8, move counter width

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begin collection for a new position
- col_done  in  NCOL  per-column "all squares transferred" flag
- col_empty  in  NCOL  per-column FIFO empty
- col_data  in  NCOL*152  column FIFO read data; column c at [152*c+151:152*c]
- col_rden  out  NCOL  one-hot FIFO read enable, one-cycle pulse
- move_data  out  MOVE_W  current move
- move_valid  out  1  move_data valid
- move_ready  in  1  consumer accepts when valid&&ready
- move_count  out  CNT_W  legal moves emitted since start, saturating at 255
- busy  out  1  collection in progress
- all_done  out  1  high from completion until next start/reset

Behaviour:
- Reset values:
  - state IDLE; col_rden=0; move_valid=0; move_data=0; move_count=0; busy=0; all_done=0; col pointer=0; slot pointer=7.
- Reset mid-operation: abort immediately, no further rden pulses, pending move dropped.
- States:
  - IDLE: wait for start. On start: ptr=0, move_count=0, all_done=0, go to POLL.
  - POLL: examine column ptr.
    - If !col_empty[ptr]: pulse col_rden[ptr] for 1 cycle, go to RDWAIT.
    - Else if col_done[ptr]: if ptr==NCOL-1 go to DONE, else ptr++ and stay in POLL.
    - Else (empty, not done): stay in POLL; wait indefinitely.
  - RDWAIT: 1-cycle FIFO read latency. Next cycle latch col_data slice into word register, slot=7, go to EMIT.
  - EMIT: examine slot bits [19*slot+18 : 19*slot].
    - If invalid bit set: skip, 1 cycle per slot.
    - Else: drive move_data and move_valid=1. Hold both stable until move_ready. On handshake, increment move_count (saturate 255).
    - Slot 7 first, down to slot 0. After slot 0 is handled, go to POLL (same ptr).
  - DONE: all_done=1, busy=0. start returns to the IDLE-start path; otherwise remain.
- busy=1 in POLL, RDWAIT, EMIT.
- start while busy: ignored.
- move_valid never asserted outside EMIT.
- A fully-invalid (terminator) word costs 8 skip cycles and emits nothing.
- Throughput: 1 move/cycle with move_ready held high. Word overhead is 2 cycles (POLL + RDWAIT).
- Columns are strictly sequential; no column is revisited after advancing.
- Simultaneous col_done and !col_empty: empty takes priority, so data is drained before advancing.

Optional Feature:
- Macro MOVE_COLLECTOR_STATS_EN.
- Defined:
  - Adds output capture_count [CNT_W-1:0]: count of emitted moves with capture bit 12 set, saturating.
  - Adds output skip_count [CNT_W-1:0]: invalid slots discarded.
  - Both clear on reset and on accepted start.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package chess_pkg holds:
  - MOVE_W and flag bit indices (FLG_INVALID=18 ... FLG_CAPTURE=12).
  - FROM/TO field ranges and SLOTS.
  - State enum (IDLE, POLL, RDWAIT, EMIT, DONE).
- One natural sub-module, move_unpacker: word register plus slot pointer, skip logic and handshake. move_collector keeps column arbitration and counters.

Test Plan:
- Column 0 holds one word with slots 7,6 valid (0x0_0F1C, 0x0_0F24), others invalid; columns 1-7 done and empty. Required: exactly two transfers in slot order, move_count=2, all_done high, col_rden[0] pulsed once.
- Same as above with move_ready low for 5 cycles on first move. Required: move_data/move_valid stable throughout; count increments only on handshake.
- Column 3 empty and not done for 20 cycles, then data arrives. Required: collector stalls in POLL with no rden to columns 4-7; resumes correctly.
- Reset asserted during EMIT of slot 4. Required: next cycle move_valid=0, busy=0, move_count=0, col_rden=0.
- Every column supplies four words of 8 valid moves. Required: move_count saturates at 255, not 256→0.
- With MOVE_COLLECTOR_STATS_EN and 3 capture moves plus 5 invalid slots in one word: capture_count=3, skip_count=5.
